// File: rtl/fetdriver_pkg.sv
// Shared types and constants for the half-bridge break-before-make gate controller.
package fetdriver_pkg;

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    DT_TO_TOP = 3'd1,
    TOP_ON    = 3'd2,
    DT_TO_BOT = 3'd3,
    BOT_ON    = 3'd4,
    FAULT_ST  = 3'd5
  } state_t;

  localparam int CNT_W_DEFAULT = 8;

  // Legal ranges for the timing parameters.
  localparam int DT_CYCLES_MIN = 1;
  localparam int DT_CYCLES_MAX = 255;
  localparam int MIN_ON_MIN    = 1;
  localparam int MIN_ON_MAX    = 255;

endpackage

// File: rtl/fetdriver_sync2.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
module fetdriver_sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [1:0] sync_ff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_ff <= 2'b00;
    else       sync_ff <= {sync_ff[0], d};
  end

  assign q = sync_ff[1];

endmodule

// File: rtl/fetdriver_deadtime_ctrl.sv
// Break-before-make gate controller: PMOS top (active-low) / NMOS bottom (active-high)
// from one PWM command, with dead time, minimum on-time and a latched fault.
module fetdriver_deadtime_ctrl
  import fetdriver_pkg::*;
#(
  parameter int DT_CYCLES = 4,
  parameter int MIN_ON    = 8,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  input  logic pwm_in,
  input  logic fault,
  input  logic fault_clr,
  output logic top_gate_n,
  output logic bot_gate,
  output logic fault_latched,
  output logic in_dt
);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             pwm_s;
  logic             dt_done, on_done;

  fetdriver_sync2 u_pwm_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (pwm_in),
    .q    (pwm_s)
  );

  assign dt_done = (cnt == CNT_W'(DT_CYCLES - 1));
  assign on_done = (cnt >= CNT_W'(MIN_ON));

  // Priority: fault, then enable, then PWM. Turning both gates off never needs dead time.
  // NOTE: nxt gets a default before any branch so no latch is inferred.
  always_comb begin
    nxt = state;
    if (fault) begin
      nxt = FAULT_ST;
    end else if (state == FAULT_ST) begin
      if (fault_clr) nxt = OFF;
    end else if (!enable) begin
      nxt = OFF;
    end else begin
      case (state)
        OFF:       nxt = pwm_s ? DT_TO_TOP : DT_TO_BOT;
        DT_TO_TOP: if (dt_done) nxt = pwm_s ? TOP_ON : DT_TO_BOT;
        TOP_ON:    if (!pwm_s && on_done) nxt = DT_TO_BOT;
        DT_TO_BOT: if (dt_done) nxt = pwm_s ? DT_TO_TOP : BOT_ON;
        BOT_ON:    if (pwm_s && on_done) nxt = DT_TO_TOP;
        default:   nxt = OFF;
      endcase
    end
  end

  // Outputs are decoded from nxt so they change on the same edge the state is entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= OFF;
      cnt           <= '0;
      top_gate_n    <= 1'b1;
      bot_gate      <= 1'b0;
      fault_latched <= 1'b0;
      in_dt         <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state)   cnt <= '0;
      else if (cnt != '1) cnt <= cnt + 1'b1;
      top_gate_n    <= (nxt != TOP_ON);
      bot_gate      <= (nxt == BOT_ON);
      fault_latched <= (nxt == FAULT_ST);
      in_dt         <= (nxt == DT_TO_TOP) || (nxt == DT_TO_BOT);
    end
  end

endmodule
